// File: rtl/fetch_request_unit.sv
// -----------------------------------------------------------------------------
// fetch_request_unit
//
// Instruction-fetch request generator sitting on the write side of the
// prefetch buffer. It owns the fetch PC and issues word-aligned read requests
// to instruction memory. It takes the in-order responses and pushes each live
// word into the prefetch buffer together with the PC it was fetched from.
// Credit accounting keeps the buffer from overflowing. A redirect reloads the
// PC, flushes the buffer and marks every in-flight request as stale so that
// its response is dropped.
//
// Ports
//   clock           single clock, all state on posedge
//   reset           asynchronous, active-high; clears all state
//   redirect_valid  branch/jump redirect pulse
//   redirect_pc     redirect target (bits [1:0] ignored)
//   mem_req_valid   request to instruction memory
//   mem_req_ready   memory accepts the request this cycle
//   mem_req_addr    request address (current fetch PC)
//   mem_rsp_valid   in-order response word valid
//   mem_rsp_data    response instruction word
//   buf_push        write one word into the prefetch buffer
//   buf_code        word being pushed
//   buf_pc          PC of the word being pushed
//   buf_flush       one-cycle pulse: buffer discards its contents
//   buf_pop         consumer removed one word from the buffer
// -----------------------------------------------------------------------------
module fetch_request_unit #(
   parameter logic [31:0] RESET_PC        = 32'h0000_0000,
   parameter int          MAX_OUTSTANDING = 2,
   parameter int          BUF_DEPTH       = 3
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        mem_req_valid,
   input  logic        mem_req_ready,
   output logic [31:0] mem_req_addr,
   input  logic        mem_rsp_valid,
   input  logic [31:0] mem_rsp_data,
   output logic        buf_push,
   output logic [31:0] buf_code,
   output logic [31:0] buf_pc,
   output logic        buf_flush,
   input  logic        buf_pop
);

   localparam int               PTR_W    = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MAX_OUTSTANDING - 1);
   localparam int               CNT_W    = 8;
   localparam logic [CNT_W-1:0] MAX_C    = CNT_W'(MAX_OUTSTANDING);
   localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(BUF_DEPTH);

   logic [31:0]      pc_reg, pc_next;
   logic [CNT_W-1:0] inflight_reg, inflight_next;
   logic [CNT_W-1:0] stale_reg, stale_next;
   logic [CNT_W-1:0] occ_reg, occ_next;
   logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
   logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
   logic             push_reg, push_next;
   logic             flush_reg, flush_next;
   logic [31:0]      code_reg, code_next;
   logic [31:0]      tag_pc_reg, tag_pc_next;

   logic [MAX_OUTSTANDING-1:0][31:0] tag_vec;

   logic [CNT_W-1:0] committed;
   logic             can_issue;
   logic             req_fire;
   logic             rsp_fire;
   logic             rsp_live;
   logic             rsp_stale;
   logic             pop_ok;
   logic             unused_redirect_bits;

   // The low address bits of a redirect target are forced to zero.
   assign unused_redirect_bits = ^redirect_pc[1:0];

   // Buffer slots already spoken for: words held plus live requests in
   // flight. Stale requests will never be pushed, so they hold no slot.
   assign committed = occ_reg + inflight_reg - stale_reg;
   assign can_issue = (committed < DEPTH_C) && (inflight_reg < MAX_C);

   // reset and redirect_valid gate the request combinationally so that a
   // redirect withdraws any pending request in its own cycle.
   assign mem_req_valid = !reset && !redirect_valid && can_issue;
   assign mem_req_addr  = pc_reg;

   assign req_fire  = mem_req_valid && mem_req_ready;
   assign rsp_fire  = mem_rsp_valid && (inflight_reg != '0);
   assign rsp_stale = rsp_fire && (stale_reg != '0);
   assign rsp_live  = rsp_fire && (stale_reg == '0);
   assign pop_ok    = buf_pop && !redirect_valid && (occ_reg != '0);

   // PC tag queue: one entry per in-flight request, written at acceptance.
   genvar gi;
   for (gi = 0; gi < MAX_OUTSTANDING; gi++) begin : g_tag
      logic [31:0] entry_reg;

      always_ff @(posedge clock or posedge reset) begin
         if (reset) begin
            entry_reg <= '0;
         end else if (req_fire && (wr_ptr_reg == PTR_W'(gi))) begin
            entry_reg <= pc_reg;
         end
      end

      assign tag_vec[gi] = entry_reg;
   end

   always_comb begin
      pc_next       = pc_reg;
      inflight_next = inflight_reg + {{(CNT_W-1){1'b0}}, req_fire}
                                   - {{(CNT_W-1){1'b0}}, rsp_fire};
      stale_next    = stale_reg;
      occ_next      = occ_reg;
      wr_ptr_next   = wr_ptr_reg;
      rd_ptr_next   = rd_ptr_reg;
      push_next     = 1'b0;
      flush_next    = redirect_valid;
      code_next     = code_reg;
      tag_pc_next   = tag_pc_reg;

      if (req_fire) begin
         pc_next     = pc_reg + 32'd4;
         wr_ptr_next = (wr_ptr_reg == PTR_LAST) ? '0 : wr_ptr_reg + 1'b1;
      end

      if (rsp_fire) begin
         rd_ptr_next = (rd_ptr_reg == PTR_LAST) ? '0 : rd_ptr_reg + 1'b1;
      end

      if (redirect_valid) begin
         // No request can be accepted in a redirect cycle, so everything
         // still in flight once this cycle's response retires is stale.
         pc_next    = {redirect_pc[31:2], 2'b00};
         stale_next = inflight_reg - {{(CNT_W-1){1'b0}}, rsp_fire};
         occ_next   = '0;
      end else begin
         if (rsp_stale) begin
            stale_next = stale_reg - 1'b1;
         end
         occ_next = occ_reg + {{(CNT_W-1){1'b0}}, rsp_live}
                            - {{(CNT_W-1){1'b0}}, pop_ok};
         if (rsp_live) begin
            push_next   = 1'b1;
            code_next   = mem_rsp_data;
            tag_pc_next = tag_vec[rd_ptr_reg];
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         pc_reg       <= RESET_PC;
         inflight_reg <= '0;
         stale_reg    <= '0;
         occ_reg      <= '0;
         wr_ptr_reg   <= '0;
         rd_ptr_reg   <= '0;
         push_reg     <= 1'b0;
         flush_reg    <= 1'b0;
         code_reg     <= '0;
         tag_pc_reg   <= '0;
      end else begin
         pc_reg       <= pc_next;
         inflight_reg <= inflight_next;
         stale_reg    <= stale_next;
         occ_reg      <= occ_next;
         wr_ptr_reg   <= wr_ptr_next;
         rd_ptr_reg   <= rd_ptr_next;
         push_reg     <= push_next;
         flush_reg    <= flush_next;
         code_reg     <= code_next;
         tag_pc_reg   <= tag_pc_next;
      end
   end

   assign buf_push  = push_reg;
   assign buf_code  = code_reg;
   assign buf_pc    = tag_pc_reg;
   assign buf_flush = flush_reg;

endmodule

// File: tb/tb_fetch_request_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_request_unit
//
// Scoreboard bench for fetch_request_unit. Stimulus pushes the expected
// request addresses and expected buffer pushes into queues; a monitor pops
// and compares whenever the DUT presents an accepted request or a push.
// A small memory model answers one cycle after acceptance with
// data = addr ^ 32'hA5A5A5A5, and a consumer model pops the buffer.
// A second instance with RESET_PC = 32'hFFFF_FFF8 covers PC wrap and
// asynchronous reset.
// -----------------------------------------------------------------------------
module tb_fetch_request_unit;

   logic clock = 1'b0;
   always #5 clock = ~clock;

   // Instance A (default parameters)
   logic        reset;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        mem_req_valid;
   logic        mem_req_ready;
   logic [31:0] mem_req_addr;
   logic        mem_rsp_valid;
   logic [31:0] mem_rsp_data;
   logic        buf_push;
   logic [31:0] buf_code;
   logic [31:0] buf_pc;
   logic        buf_flush;
   logic        buf_pop;

   // Instance B (wrap / async reset)
   logic        rst_b;
   logic        redirect_b;
   logic [31:0] redirect_pc_b;
   logic        req_valid_b;
   logic        req_ready_b;
   logic [31:0] req_addr_b;
   logic        rsp_valid_b;
   logic [31:0] rsp_data_b;
   logic        push_b;
   logic [31:0] code_b;
   logic [31:0] pc_b;
   logic        flush_b;
   logic        pop_b;

   fetch_request_unit dut (
      .clock          (clock),
      .reset          (reset),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .mem_req_valid  (mem_req_valid),
      .mem_req_ready  (mem_req_ready),
      .mem_req_addr   (mem_req_addr),
      .mem_rsp_valid  (mem_rsp_valid),
      .mem_rsp_data   (mem_rsp_data),
      .buf_push       (buf_push),
      .buf_code       (buf_code),
      .buf_pc         (buf_pc),
      .buf_flush      (buf_flush),
      .buf_pop        (buf_pop)
   );

   fetch_request_unit #(
      .RESET_PC        (32'hFFFF_FFF8),
      .MAX_OUTSTANDING (4),
      .BUF_DEPTH       (3)
   ) dut_b (
      .clock          (clock),
      .reset          (rst_b),
      .redirect_valid (redirect_b),
      .redirect_pc    (redirect_pc_b),
      .mem_req_valid  (req_valid_b),
      .mem_req_ready  (req_ready_b),
      .mem_req_addr   (req_addr_b),
      .mem_rsp_valid  (rsp_valid_b),
      .mem_rsp_data   (rsp_data_b),
      .buf_push       (push_b),
      .buf_code       (code_b),
      .buf_pc         (pc_b),
      .buf_flush      (flush_b),
      .buf_pop        (pop_b)
   );

   int checks = 0;
   int passes = 0;
   int acc_cnt = 0;       // accepted requests seen by the monitor
   int bcount = 0;        // words held in the modelled prefetch buffer
   int pop_req = 0;       // one-shot pops requested by stimulus
   int pop_done = 0;      // one-shot pops performed by the consumer
   logic pop_en = 1'b0;
   logic mem_hold = 1'b0;

   logic [31:0] req_q[$];
   logic [63:0] push_q[$];
   logic [31:0] mem_q[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %h, expected %h", name, act, exp);
   endtask

   function automatic logic [63:0] exp_word(input logic [31:0] addr);
      return {addr, addr ^ 32'hA5A5A5A5};
   endfunction

   // Monitor / scoreboard
   initial begin
      logic [31:0] ea;
      logic [63:0] ew;
      forever begin
         @(negedge clock);
         if (reset) begin
            bcount = 0;
         end else begin
            if (mem_req_valid && mem_req_ready) begin
               acc_cnt++;
               mem_q.push_back(mem_req_addr);
               $display("req  addr=%h", mem_req_addr);
               if (req_q.size() == 0) begin
                  checks++;
                  $display("FAIL req_unexpected: got addr %h, expected no request", mem_req_addr);
               end else begin
                  ea = req_q.pop_front();
                  check("req_addr", mem_req_addr, ea);
               end
            end
            if (buf_push) begin
               $display("push pc=%h code=%h", buf_pc, buf_code);
               if (push_q.size() == 0) begin
                  checks++;
                  $display("FAIL push_unexpected: got pc %h, expected no push", buf_pc);
               end else begin
                  ew = push_q.pop_front();
                  check("push_pc", buf_pc, ew[63:32]);
                  check("push_code", buf_code, ew[31:0]);
               end
            end
            if (buf_flush) bcount = 0;
            else bcount = bcount + (buf_push ? 1 : 0) - ((buf_pop && bcount > 0) ? 1 : 0);
         end
      end
   end

   // Memory model: in-order, one response per cycle, one cycle after acceptance
   initial begin
      logic [31:0] a;
      mem_rsp_valid = 1'b0;
      mem_rsp_data  = '0;
      forever begin
         @(posedge clock); #1;
         mem_rsp_valid = 1'b0;
         mem_rsp_data  = '0;
         if (reset) begin
            mem_q.delete();
         end else if (!mem_hold && mem_q.size() > 0) begin
            a = mem_q.pop_front();
            mem_rsp_valid = 1'b1;
            mem_rsp_data  = a ^ 32'hA5A5A5A5;
         end
      end
   end

   // Consumer model
   initial begin
      buf_pop = 1'b0;
      forever begin
         @(posedge clock); #1;
         buf_pop = 1'b0;
         if (pop_req != pop_done) begin
            buf_pop = 1'b1;
            pop_done++;
         end else if (pop_en && bcount > 0) begin
            buf_pop = 1'b1;
         end
      end
   end

   // Lets exactly n requests be accepted, then drops ready.
   task automatic issue(input int n);
      int target;
      int cyc;
      target = acc_cnt + n;
      cyc = 0;
      while (acc_cnt < target && cyc < 40) begin
         @(posedge clock); #1;
         mem_req_ready = 1'b1;
         @(negedge clock); #1;
         cyc++;
      end
      @(posedge clock); #1;
      mem_req_ready = 1'b0;
      @(negedge clock); #1;
      check("issue_count", 32'(acc_cnt), 32'(target));
   endtask

   task automatic wait_drain(input string name);
      int cyc;
      cyc = 0;
      while ((push_q.size() != 0 || bcount != 0) && cyc < 60) begin
         @(negedge clock); #1;
         cyc++;
      end
      check(name, 32'(push_q.size()), 32'd0);
   endtask

   task automatic run_ready(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clock); #1;
         mem_req_ready = 1'b1;
         @(negedge clock); #1;
      end
   endtask

   // Stimulus
   initial begin
      int a0;
      reset = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc = '0;
      mem_req_ready = 1'b0;
      rst_b = 1'b1;
      redirect_b = 1'b0;
      redirect_pc_b = '0;
      req_ready_b = 1'b0;
      rsp_valid_b = 1'b0;
      rsp_data_b = '0;
      pop_b = 1'b0;

      repeat (2) @(negedge clock);
      #1;
      check("rst_req_valid", {31'd0, mem_req_valid}, 32'd0);
      check("rst_req_addr", mem_req_addr, 32'h0000_0000);
      check("rst_push", {31'd0, buf_push}, 32'd0);
      check("rst_code", buf_code, 32'd0);
      check("rst_pc", buf_pc, 32'd0);
      check("rst_flush", {31'd0, buf_flush}, 32'd0);
      check("rstb_req_addr", req_addr_b, 32'hFFFF_FFF8);
      check("rstb_outputs", {28'd0, req_valid_b, push_b, flush_b, 1'b0}, 32'd0);
      check("rstb_code_pc", code_b | pc_b, 32'd0);

      // First request right after reset release
      @(posedge clock); #1;
      reset = 1'b0;
      @(negedge clock); #1;
      check("first_req_valid", {31'd0, mem_req_valid}, 32'd1);
      check("first_req_addr", mem_req_addr, 32'h0000_0000);

      // Streaming with a consumer that pops whenever it holds a word
      pop_en = 1'b1;
      for (int i = 0; i < 8; i++) begin
         req_q.push_back(32'(i * 4));
         push_q.push_back(exp_word(32'(i * 4)));
      end
      issue(8);
      wait_drain("stream_drain");

      // No pops: credits allow exactly three requests
      pop_en = 1'b0;
      a0 = acc_cnt;
      req_q.push_back(32'h20); push_q.push_back(exp_word(32'h20));
      req_q.push_back(32'h24); push_q.push_back(exp_word(32'h24));
      req_q.push_back(32'h28); push_q.push_back(exp_word(32'h28));
      run_ready(12);
      check("nopop_accepts", 32'(acc_cnt - a0), 32'd3);
      check("nopop_valid_low", {31'd0, mem_req_valid}, 32'd0);
      req_q.push_back(32'h2C); push_q.push_back(exp_word(32'h2C));
      pop_req++;
      run_ready(10);
      check("onepop_accepts", 32'(acc_cnt - a0), 32'd4);
      check("onepop_valid_low", {31'd0, mem_req_valid}, 32'd0);
      @(posedge clock); #1;
      mem_req_ready = 1'b0;
      pop_en = 1'b1;
      wait_drain("nopop_drain");

      // Reset again, then hold ready low for 5 cycles
      @(posedge clock); #1;
      reset = 1'b1;
      @(negedge clock); #1;
      check("reset2_valid", {31'd0, mem_req_valid}, 32'd0);
      check("reset2_addr", mem_req_addr, 32'h0000_0000);
      @(posedge clock); #1;
      @(posedge clock); #1;
      reset = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(posedge clock); #1;
         @(negedge clock); #1;
         check("stall_valid", {31'd0, mem_req_valid}, 32'd1);
         check("stall_addr", mem_req_addr, 32'h0000_0000);
      end
      req_q.push_back(32'h0); push_q.push_back(exp_word(32'h0));
      issue(1);
      wait_drain("stall_drain");

      // Redirect with two requests in flight
      mem_hold = 1'b1;
      req_q.push_back(32'h4);
      req_q.push_back(32'h8);
      issue(2);
      @(posedge clock); #1;
      redirect_valid = 1'b1;
      redirect_pc = 32'h0000_1003;
      @(negedge clock); #1;
      check("redir_valid_low", {31'd0, mem_req_valid}, 32'd0);
      @(posedge clock); #1;
      redirect_valid = 1'b0;
      @(negedge clock); #1;
      check("redir_flush", {31'd0, buf_flush}, 32'd1);
      check("redir_addr", mem_req_addr, 32'h0000_1000);
      check("redir_no_push", {31'd0, buf_push}, 32'd0);
      @(posedge clock); #1;
      @(negedge clock); #1;
      check("redir_flush_once", {31'd0, buf_flush}, 32'd0);
      req_q.push_back(32'h1000); push_q.push_back(exp_word(32'h1000));
      req_q.push_back(32'h1004); push_q.push_back(exp_word(32'h1004));
      mem_hold = 1'b0;
      issue(2);
      wait_drain("redir_drain");

      // Redirect coinciding with a response and a pop
      pop_en = 1'b0;
      req_q.push_back(32'h1008); push_q.push_back(exp_word(32'h1008));
      issue(1);
      repeat (3) begin
         @(negedge clock); #1;
      end
      mem_hold = 1'b1;
      req_q.push_back(32'h100C);
      issue(1);
      mem_hold = 1'b0;
      pop_req++;
      @(posedge clock); #1;
      redirect_valid = 1'b1;
      redirect_pc = 32'h0000_2000;
      @(negedge clock); #1;
      check("redir2_valid_low", {31'd0, mem_req_valid}, 32'd0);
      @(posedge clock); #1;
      redirect_valid = 1'b0;
      @(negedge clock); #1;
      check("redir2_flush", {31'd0, buf_flush}, 32'd1);
      check("redir2_no_push", {31'd0, buf_push}, 32'd0);
      check("redir2_addr", mem_req_addr, 32'h0000_2000);
      a0 = acc_cnt;
      req_q.push_back(32'h2000); push_q.push_back(exp_word(32'h2000));
      req_q.push_back(32'h2004); push_q.push_back(exp_word(32'h2004));
      req_q.push_back(32'h2008); push_q.push_back(exp_word(32'h2008));
      run_ready(12);
      check("redir2_credits", 32'(acc_cnt - a0), 32'd3);
      check("redir2_valid_low_after", {31'd0, mem_req_valid}, 32'd0);
      @(posedge clock); #1;
      mem_req_ready = 1'b0;
      pop_en = 1'b1;
      wait_drain("redir2_drain");

      // PC wrap and asynchronous reset on instance B
      @(posedge clock); #1;
      rst_b = 1'b0;
      req_ready_b = 1'b1;
      @(negedge clock); #1;
      $display("reqb addr=%h", req_addr_b);
      check("wrap_valid0", {31'd0, req_valid_b}, 32'd1);
      check("wrap_addr0", req_addr_b, 32'hFFFF_FFF8);
      @(negedge clock); #1;
      $display("reqb addr=%h", req_addr_b);
      check("wrap_valid1", {31'd0, req_valid_b}, 32'd1);
      check("wrap_addr1", req_addr_b, 32'hFFFF_FFFC);
      @(negedge clock); #1;
      $display("reqb addr=%h", req_addr_b);
      check("wrap_valid2", {31'd0, req_valid_b}, 32'd1);
      check("wrap_addr2", req_addr_b, 32'h0000_0000);
      #1;
      rst_b = 1'b1;
      #1;
      check("async_valid", {31'd0, req_valid_b}, 32'd0);
      check("async_addr", req_addr_b, 32'hFFFF_FFF8);
      check("async_push_flush", {30'd0, push_b, flush_b}, 32'd0);
      req_ready_b = 1'b0;

      check("req_q_empty", 32'(req_q.size()), 32'd0);
      check("push_q_empty", 32'(push_q.size()), 32'd0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1);
   end

endmodule
